handshake_rx_mux: RTL and testbench

- Destination-clock side of a 4-phase req/ack clock-domain crossing, generalised to CHANNELS independent source channels of WIDTH bits each.
- Each channel's asynchronous request passes through a SYNC_STAGES flop chain. The channel's data word is captured into a per-channel holding buffer and acknowledged back to the source.
- A round-robin arbiter merges the buffered words into one valid/ready output stream, tagged with the channel index.
- Sits at the boundary of the clk domain and receives words from peripherals running on unrelated clocks.

---
 rtl/handshake_rx_mux.sv | 131 +++++++++++++
 tb/tb_handshake_rx_mux.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_rx_mux.sv
// Destination side of a multi-channel 4-phase req/ack crossing: per-channel
// synchronisers, capture FSMs and holding buffers, merged by a round-robin arbiter.
module handshake_rx_mux #(
  parameter int WIDTH       = 16,
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       src_req,
  input  logic [CHANNELS*WIDTH-1:0] src_data,
  output logic [CHANNELS-1:0]       src_ack,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [CHAN_W-1:0]         out_chan
);

  // state   | meaning
  // IDLE    | no word held, ack low, waiting for req_s
  // HOLD    | word in buffer, ack high, requesting the arbiter
  // RELEASE | word delivered, ack high, waiting for req_s to fall
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_RELEASE} state_t;

  logic [SYNC_STAGES-1:0] r_sync [CHANNELS];
  logic [WIDTH-1:0]       r_buf  [CHANNELS];
  state_t                 r_state [CHANNELS];
  state_t                 w_next  [CHANNELS];
  logic [CHANNELS-1:0]    r_ack;
  logic [CHANNELS-1:0]    w_req_s;
  logic [CHANNELS-1:0]    w_pend;
  logic [CHANNELS-1:0]    w_grant;
  logic [CHAN_W-1:0]      r_ptr;
  logic [CHAN_W-1:0]      w_gidx;
  logic [CHAN_W-1:0]      w_ptr_next;
  logic                   w_any;
  logic                   w_load;
  logic                   w_fire;
  logic                   r_valid;
  logic [WIDTH-1:0]       r_data;
  logic [CHAN_W-1:0]      r_chan;
  int                     w_idx;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_req_s[i] = r_sync[i][SYNC_STAGES-1];
      w_pend[i]  = (r_state[i] == ST_HOLD);
    end
  end

  // Round-robin search starting at r_ptr; first pending channel wins.
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    w_idx  = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= CHANNELS) w_idx = w_idx - CHANNELS;
      if (!w_any && w_pend[w_idx]) begin
        w_any  = 1'b1;
        w_gidx = CHAN_W'(w_idx);
      end
    end
  end

  assign w_load     = !r_valid || out_ready;
  assign w_fire     = w_load && w_any;
  assign w_ptr_next = (w_gidx == CHAN_W'(CHANNELS - 1)) ? '0 : w_gidx + 1'b1;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_grant[i] = w_fire && (w_gidx == CHAN_W'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_next[i] = r_state[i];
      case (r_state[i])
        ST_IDLE:    if (w_req_s[i]) w_next[i] = ST_HOLD;
        ST_HOLD:    if (w_grant[i]) w_next[i] = w_req_s[i] ? ST_RELEASE : ST_IDLE;
        ST_RELEASE: if (!w_req_s[i]) w_next[i] = ST_IDLE;
        default:    w_next[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_sync[i]  <= '0;
        r_buf[i]   <= '0;
        r_state[i] <= ST_IDLE;
      end
      r_ack <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_sync[i]  <= {r_sync[i][SYNC_STAGES-2:0], src_req[i]};
        r_state[i] <= w_next[i];
        r_ack[i]   <= (w_next[i] != ST_IDLE);
        if (r_state[i] == ST_IDLE && w_req_s[i]) r_buf[i] <= src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register: reloads whenever empty or being consumed this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_data  <= r_buf[w_gidx];
        r_chan  <= w_gidx;
        r_ptr   <= w_ptr_next;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign src_ack   = r_ack;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_chan  = r_chan;

endmodule

// File: tb/tb_handshake_rx_mux.sv
// Bench for handshake_rx_mux: directed latency/fairness/backpressure/reset steps,
// then random 4-phase sources checked against per-channel expected-word queues.
module tb_handshake_rx_mux;
  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   src_req;
  logic [N*W-1:0] src_data;
  wire  [N-1:0]   src_ack;
  wire            out_valid;
  logic           out_ready;
  wire  [W-1:0]   out_data;
  wire  [1:0]     out_chan;

  logic b_req, b_data, b_ready;
  wire  b_ack, b_valid, b_odata, b_chan;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q [N][$];

  always #5 clk = ~clk;

  handshake_rx_mux #(.WIDTH(W), .CHANNELS(N), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_data(src_data), .src_ack(src_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan)
  );

  handshake_rx_mux #(.WIDTH(1), .CHANNELS(1), .SYNC_STAGES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .src_req(b_req), .src_data(b_data), .src_ack(b_ack),
    .out_valid(b_valid), .out_ready(b_ready), .out_data(b_odata), .out_chan(b_chan)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int ch, input logic [W-1:0] v);
    src_data[ch*W +: W] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_req = '0;
    src_data = '0;
    out_ready = 1'b0;
    b_req = 1'b0;
    b_data = 1'b0;
    b_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input int ch, input logic val, input string tag);
    for (int n = 0; n < 40 && src_ack[ch] !== val; n++) tick();
    check(tag, src_ack[ch], val);
  endtask

  task automatic wait_valid(input string tag);
    for (int n = 0; n < 40 && out_valid !== 1'b1; n++) tick();
    check(tag, out_valid, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int st [N];
    logic hv;
    logic [W-1:0] hd;
    logic [1:0] hc;
    logic [W-1:0] w;

    // Reset state
    do_reset();
    check("rst_valid", out_valid, 0);
    check("rst_ack", src_ack, 0);
    check("rst_data", out_data, 0);
    check("rst_chan", out_chan, 0);

    // Single transfer on ch2
    out_ready = 1'b1;
    set_data(2, 16'hA5C3);
    src_req[2] = 1'b1;
    tick(); check("t1_ack_e1", src_ack[2], 0);
    tick(); check("t1_ack_e2", src_ack[2], 0);
    tick(); check("t1_ack_e3", src_ack[2], 1); check("t1_valid_e3", out_valid, 0);
    tick(); check("t1_valid_e4", out_valid, 1);
    check("t1_data_e4", out_data, 16'hA5C3); check("t1_chan_e4", out_chan, 2);
    src_req[2] = 1'b0;
    tick(); check("t1_valid_clr", out_valid, 0); check("t1_ack_f1", src_ack[2], 1);
    tick(); check("t1_ack_f2", src_ack[2], 1);
    tick(); check("t1_ack_f3", src_ack[2], 0);

    // Fairness: two rounds with all channels requesting together
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, W'(16'h1000 + i));
    src_req = '1;
    tick(); tick(); tick();
    check("fair_acks", src_ack, 4'hF);
    for (int i = 0; i < N; i++) begin
      tick();
      check("fair_r1_valid", out_valid, 1);
      check("fair_r1_chan", out_chan, i);
      check("fair_r1_data", out_data, 16'h1000 + i);
    end
    tick(); check("fair_r1_empty", out_valid, 0);
    src_req = '0;
    for (int i = 0; i < N; i++) wait_ack(i, 1'b0, "fair_ack_low");
    for (int i = 0; i < N; i++) set_data(i, W'(16'h2000 + i));
    src_req = '1;
    wait_valid("fair_r2_start");
    for (int i = 0; i < N; i++) begin
      check("fair_r2_chan", out_chan, i);
      check("fair_r2_data", out_data, 16'h2000 + i);
      tick();
    end
    src_req = '0;

    // Backpressure: ch1 held at output, ch3 waits in HOLD
    do_reset();
    set_data(1, 16'hBEEF);
    src_req[1] = 1'b1;
    tick();
    set_data(3, 16'h3333);
    src_req[3] = 1'b1;
    wait_valid("bp_valid");
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_valid_hold", out_valid, 1);
      check("bp_data_hold", out_data, 16'hBEEF);
      check("bp_chan_hold", out_chan, 1);
      check("bp_ack3_hold", src_ack[3], 1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_next_valid", out_valid, 1);
    check("bp_next_chan", out_chan, 3);
    check("bp_next_data", out_data, 16'h3333);
    src_req = '0;
    tick();

    // Early req release while blocked in HOLD
    do_reset();
    set_data(2, 16'h2222);
    src_req[2] = 1'b1;
    wait_valid("er_valid");
    set_data(0, 16'h0A0A);
    src_req[0] = 1'b1;
    wait_ack(0, 1'b1, "er_ack_up");
    src_req[0] = 1'b0;
    repeat (6) tick();
    check("er_ack_held", src_ack[0], 1);
    check("er_chan_held", out_chan, 2);
    out_ready = 1'b1;
    tick();
    check("er_grant_chan", out_chan, 0);
    check("er_grant_data", out_data, 16'h0A0A);
    check("er_ack_fall", src_ack[0], 0);
    src_req = '0;

    // Asynchronous reset mid-operation
    do_reset();
    set_data(1, 16'h1111); set_data(2, 16'h2222); set_data(3, 16'h3333);
    src_req = 4'b1110;
    wait_valid("rm_valid");
    tick();
    check("rm_acks", src_ack, 4'b1110);
    rst_n = 1'b0;
    #1;
    check("rm_valid_async", out_valid, 0);
    check("rm_ack_async", src_ack, 0);
    check("rm_data_async", out_data, 0);
    src_req = '0;
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    set_data(3, 16'h7777);
    src_req[3] = 1'b1;
    wait_valid("rm_fresh_valid");
    check("rm_fresh_data", out_data, 16'h7777);
    check("rm_fresh_chan", out_chan, 3);
    src_req = '0;

    // One channel, three sync stages, one-bit data
    do_reset();
    for (int v = 1; v >= 0; v--) begin
      b_data = 1'(v);
      b_req = 1'b1;
      tick(); tick(); tick();
      check("b_ack_e3", b_ack, 0);
      tick(); check("b_ack_e4", b_ack, 1);
      tick();
      check("b_valid_e5", b_valid, 1);
      check("b_data", b_odata, v);
      check("b_chan", b_chan, 0);
      b_req = 1'b0;
      for (int n = 0; n < 40 && b_ack !== 1'b0; n++) tick();
      check("b_ack_low", b_ack, 0);
    end

    // Random traffic against per-channel word queues
    do_reset();
    for (int i = 0; i < N; i++) st[i] = 0;
    hv = 1'b0; hd = '0; hc = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (hv) begin
        check("rnd_hold_valid", out_valid, 1);
        check("rnd_hold_data", out_data, hd);
        check("rnd_hold_chan", out_chan, hc);
      end
      if (out_valid && out_ready) begin
        check("rnd_word_expected", exp_q[out_chan].size() != 0, 1);
        if (exp_q[out_chan].size() != 0) check("rnd_data", out_data, exp_q[out_chan].pop_front());
      end
      hv = out_valid && !out_ready;
      hd = out_data;
      hc = out_chan;
      for (int i = 0; i < N; i++) begin
        case (st[i])
          0: if (cyc < 3000 && $urandom_range(0, 3) == 0) begin
               w = W'($urandom);
               set_data(i, w);
               src_req[i] = 1'b1;
               exp_q[i].push_back(w);
               st[i] = 1;
             end
          1: if (src_ack[i] && $urandom_range(0, 1) == 1) begin
               src_req[i] = 1'b0;
               st[i] = 2;
             end
          default: if (!src_ack[i]) st[i] = 0;
        endcase
      end
      tick();
    end
    for (int i = 0; i < N; i++) begin
      check("rnd_drained", exp_q[i].size(), 0);
      check("rnd_src_idle", st[i], 0);
    end
    check("rnd_final_ack", src_ack, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
